abm_frame_writer: RTL and testbench

Transmit-side counterpart of the ABM update notification path. It accepts one ABM frame at a time from an AXI-Stream source and writes it into a ping-pong (two-bank) ABM RAM. After the final word of a correctly sized frame is committed, it swaps the active bank and strobes `abm_updated` for one cycle. One instance per ABM block; its `abm_updated` output feeds the per-block update input of the ABM ready notifier.

---
 rtl/abm_frame_writer_if.sv | 24 ++
 rtl/abm_frame_writer.sv | 141 ++++++++++++++
 tb/tb_abm_frame_writer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/abm_frame_writer_if.sv
// Stream-in / RAM-write bundle of the ABM frame writer.
// master is the stream source and RAM side; slave is the writer itself.
interface abm_frame_writer_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          ram_wr_en;
  logic [AW:0]   ram_wr_addr;
  logic [DW-1:0] ram_wr_data;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready, ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/abm_frame_writer.sv
// Writes one AXI-Stream ABM frame at a time into the inactive half of a
// ping-pong RAM and flips the active bank once a correctly sized frame lands.
module abm_frame_writer #(
  parameter int DW          = 32,
  parameter int FRAME_WORDS = 64,
  parameter int AW          = $clog2(FRAME_WORDS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  abm_frame_writer_if.slave    bus,
  output logic                 active_bank,
  output logic                 abm_updated,
  output logic                 frame_error,
  output logic [31:0]          update_count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_WORDS - 1);

  typedef enum logic {S_RECV, S_DISCARD} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] widx, widx_nxt;
  logic          tready_r;
  logic          hs;
  logic          wr_req, commit_req, err_req;

  // Bank the current frame is written into; flips as soon as a good last
  // word is accepted so the next frame's first word already targets the
  // bank that is about to become inactive.
  logic          wr_bank;
  logic          bank_r;
  logic [31:0]   count_r;

  logic          wr_en_p1;
  logic [AW:0]   wr_addr_p1;
  logic [DW-1:0] wr_data_p1;
  logic          commit_p1;
  logic          err_p1;
  logic          upd_p2;

  function automatic logic [31:0] count_inc(input logic [31:0] c);
    return c + 32'd1;
  endfunction

  assign hs = bus.s_axis_tvalid & tready_r;

  always_comb begin
    state_nxt  = state;
    widx_nxt   = widx;
    wr_req     = 1'b0;
    commit_req = 1'b0;
    err_req    = 1'b0;
    case (state)
      S_RECV: begin
        if (hs) begin
          wr_req = 1'b1;
          if (widx == LAST_IDX) begin
            widx_nxt = '0;
            if (bus.s_axis_tlast) begin
              commit_req = 1'b1;
            end else begin
              err_req   = 1'b1;
              state_nxt = S_DISCARD;
            end
          end else if (bus.s_axis_tlast) begin
            err_req  = 1'b1;
            widx_nxt = '0;
          end else begin
            widx_nxt = widx + AW'(1);
          end
        end
      end
      S_DISCARD: begin
        if (hs && bus.s_axis_tlast) begin
          state_nxt = S_RECV;
        end
      end
      default: state_nxt = S_RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_RECV;
      widx     <= '0;
      tready_r <= 1'b0;
      wr_bank  <= 1'b1;
    end else begin
      state    <= state_nxt;
      widx     <= widx_nxt;
      tready_r <= 1'b1;
      if (commit_req) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // p1: RAM write and error strobe for the word accepted at the previous edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      commit_p1  <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      wr_en_p1  <= wr_req;
      commit_p1 <= commit_req;
      err_p1    <= err_req;
      if (wr_req) begin
        wr_addr_p1 <= {wr_bank, widx};
        wr_data_p1 <= bus.s_axis_tdata;
      end
    end
  end

  // p2: commit after the last word is already in RAM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      upd_p2  <= 1'b0;
      bank_r  <= 1'b0;
      count_r <= '0;
    end else begin
      upd_p2 <= commit_p1;
      if (commit_p1) begin
        bank_r  <= ~bank_r;
        count_r <= count_inc(count_r);
      end
    end
  end

  assign bus.s_axis_tready = tready_r;
  assign bus.ram_wr_en     = wr_en_p1;
  assign bus.ram_wr_addr   = wr_addr_p1;
  assign bus.ram_wr_data   = wr_data_p1;
  assign active_bank       = bank_r;
  assign abm_updated       = upd_p2;
  assign frame_error       = err_p1;
  assign update_count      = count_r;

endmodule

// File: tb/tb_abm_frame_writer.sv
// Scoreboard bench for abm_frame_writer: the driver queues expected writes,
// commits and errors with their cycle tags; a monitor pops and compares.
module tb_abm_frame_writer;
  localparam int DW = 32;
  localparam int FW = 64;
  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        active_bank, abm_updated, frame_error;
  logic [31:0] update_count;

  always #5 clk = ~clk;

  abm_frame_writer_if #(.DW(DW), .AW(AW)) bus ();

  abm_frame_writer #(.DW(DW), .FRAME_WORDS(FW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus.slave),
    .active_bank  (active_bank),
    .abm_updated  (abm_updated),
    .frame_error  (frame_error),
    .update_count (update_count)
  );

  typedef struct { int tag; logic [AW:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int tag; logic bank; logic [31:0] cnt; } upd_t;

  wr_t  wq[$];
  upd_t uq[$];
  int   eq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // spec-level model of the writer's bookkeeping
  logic [AW-1:0] m_widx = '0;
  logic          m_disc = 1'b0;
  logic          m_wbank = 1'b1;
  logic          m_active = 1'b0;
  logic [31:0]   m_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    wr_t  w;
    upd_t u;
    int   t;
    while (wq.size() > 0 && wq[0].tag < cyc) begin
      w = wq.pop_front();
      checks++; errors++;
      $display("FAIL wr_missing tag=%0d addr=%0d required a write at that cycle", w.tag, w.addr);
    end
    while (uq.size() > 0 && uq[0].tag < cyc) begin
      u = uq.pop_front();
      checks++; errors++;
      $display("FAIL upd_missing tag=%0d required abm_updated at that cycle", u.tag);
    end
    while (eq.size() > 0 && eq[0] < cyc) begin
      t = eq.pop_front();
      checks++; errors++;
      $display("FAIL err_missing tag=%0d required frame_error at that cycle", t);
    end
    if (bus.ram_wr_en) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected cyc=%0d addr=%0d data=%0h required no write", cyc, bus.ram_wr_addr, bus.ram_wr_data);
      end else begin
        w = wq.pop_front();
        if (w.tag != cyc || w.addr != bus.ram_wr_addr || w.data != bus.ram_wr_data) begin
          errors++;
          $display("FAIL wr cyc=%0d addr=%0d data=%0h required cyc=%0d addr=%0d data=%0h",
                   cyc, bus.ram_wr_addr, bus.ram_wr_data, w.tag, w.addr, w.data);
        end
      end
    end
    if (abm_updated) begin
      checks++;
      if (uq.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected cyc=%0d required no abm_updated", cyc);
      end else begin
        u = uq.pop_front();
        if (u.tag != cyc || u.bank != active_bank || u.cnt != update_count) begin
          errors++;
          $display("FAIL upd cyc=%0d bank=%0d count=%0d required cyc=%0d bank=%0d count=%0d",
                   cyc, active_bank, update_count, u.tag, u.bank, u.cnt);
        end
      end
    end
    if (frame_error) begin
      checks++;
      if (eq.size() == 0) begin
        errors++;
        $display("FAIL err_unexpected cyc=%0d required no frame_error", cyc);
      end else begin
        t = eq.pop_front();
        if (t != cyc) begin
          errors++;
          $display("FAIL err cyc=%0d required cyc=%0d", cyc, t);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int h;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = last;
    h = cyc + 1;
    chk("tready", {31'd0, bus.s_axis_tready}, 32'd1);
    if (!m_disc) begin
      wq.push_back('{h, {m_wbank, m_widx}, d});
      if (m_widx == AW'(FW - 1)) begin
        m_widx = '0;
        if (last) begin
          m_wbank  = ~m_wbank;
          m_active = ~m_active;
          m_count  = m_count + 32'd1;
          uq.push_back('{h + 1, m_active, m_count});
        end else begin
          eq.push_back(h);
          m_disc = 1'b1;
        end
      end else if (last) begin
        eq.push_back(h);
        m_widx = '0;
      end else begin
        m_widx = m_widx + AW'(1);
      end
    end else if (last) begin
      m_disc = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tready", {31'd0, bus.s_axis_tready}, 32'd0);
    chk("rst_wr_en", {31'd0, bus.ram_wr_en}, 32'd0);
    chk("rst_wr_addr", {25'd0, bus.ram_wr_addr}, 32'd0);
    chk("rst_wr_data", bus.ram_wr_data, 32'd0);
    chk("rst_active_bank", {31'd0, active_bank}, 32'd0);
    chk("rst_abm_updated", {31'd0, abm_updated}, 32'd0);
    chk("rst_frame_error", {31'd0, frame_error}, 32'd0);
    chk("rst_update_count", update_count, 32'd0);
  endtask

  task automatic model_reset();
    m_widx = '0; m_disc = 1'b0; m_wbank = 1'b1; m_active = 1'b0; m_count = '0;
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    resetn = 1'b1;
    idle(2);

    // good frame into bank 1
    for (int i = 0; i < FW; i++) send(DW'(i), i == FW - 1);
    idle(4);
    chk("good_active_bank", {31'd0, active_bank}, 32'd1);
    chk("good_update_count", update_count, 32'd1);

    // short frame, then a good frame into bank 0 from index 0
    for (int i = 0; i <= 10; i++) send(DW'(32'h100 + i), i == 10);
    idle(3);
    chk("short_active_bank", {31'd0, active_bank}, 32'd1);
    chk("short_update_count", update_count, 32'd1);
    for (int i = 0; i < FW; i++) send(DW'(32'h200 + i), i == FW - 1);
    idle(4);
    chk("after_short_active_bank", {31'd0, active_bank}, 32'd0);
    chk("after_short_update_count", update_count, 32'd2);

    // long frame: 70 words, only 64 written
    for (int i = 0; i < 70; i++) send(DW'(32'h300 + i), i == 69);
    idle(3);
    chk("long_active_bank", {31'd0, active_bank}, 32'd0);
    chk("long_update_count", update_count, 32'd2);

    // three back-to-back frames, banks 1,0,1
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < FW; i++) send(DW'(32'h1000 * (f + 1) + i), i == FW - 1);
    idle(4);
    chk("b2b_active_bank", {31'd0, active_bank}, 32'd1);
    chk("b2b_update_count", update_count, 32'd5);

    // reset after word 30 of a frame
    for (int i = 0; i <= 30; i++) send(DW'(32'h5000 + i), 1'b0);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset_outputs();
    resetn = 1'b1;
    idle(1);
    for (int i = 0; i < FW; i++) send(DW'(32'h6000 + i), i == FW - 1);
    idle(4);
    chk("rst_mid_active_bank", {31'd0, active_bank}, 32'd1);
    chk("rst_mid_update_count", update_count, 32'd1);

    // tvalid gaps inside a frame
    for (int i = 0; i < FW; i++) begin
      idle($urandom_range(0, 2));
      send(DW'(32'h7000 + i), i == FW - 1);
    end
    idle(5);
    chk("gap_active_bank", {31'd0, active_bank}, 32'd0);
    chk("gap_update_count", update_count, 32'd2);
    chk("wq_drained", wq.size(), 32'd0);
    chk("uq_drained", uq.size(), 32'd0);
    chk("eq_drained", eq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
